// File: rtl/timer_pkg.sv
// Shared constants and types for the IO-bus interval timer.
package timer_pkg;

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_RELOAD   = 3'd1;
    localparam logic [2:0] OFF_COUNT    = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IE     = 2;
    localparam int STATUS_PEND = 0;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

endpackage

// File: rtl/timer_prescaler.sv
// Clock divider: one-cycle tick every divisor+1 clocks while enabled.
// Latency: tick is combinational from the registered phase counter; no backpressure.
// Counter is held at 0 while disabled and restarts from 0 on clr.
module timer_prescaler (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] divisor,
    output logic        tick
);

    logic [15:0] r_pcnt;

    assign tick = en && (r_pcnt == divisor);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcnt <= '0;
        end else if (clr || !en || tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end

endmodule

// File: rtl/timer_io_wrap.sv
// Programmable interval timer on the 8-bit IO bus; periodic or one-shot level interrupt.
// Latency: reads return 1 cycle after i_IO_re (0 otherwise); o_intr follows PEND&IE by 1 cycle.
// No backpressure: every strobe is accepted in its cycle.
module timer_io_wrap
    import timer_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = 8'h20,
    parameter logic [15:0] PRESCALE_RST = 16'd49
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_IO_re,
    input  logic        i_IO_we,
    input  logic [7:0]  i_IO_addr,
    input  logic [15:0] i_IO_data,
    output logic [15:0] o_IO_data,
    output logic        o_intr
);

    state_t      r_state;
    logic        r_auto;
    logic        r_ie;
    logic        r_pend;
    logic [15:0] r_reload;
    logic [15:0] r_count;
    logic [15:0] r_prescale;
    logic [15:0] r_rdata;
    logic        r_intr;

    logic [7:0]  w_off;
    logic        w_hit;
    logic        w_wr_ctrl;
    logic        w_wr_reload;
    logic        w_wr_count;
    logic        w_wr_status;
    logic        w_wr_prescale;
    logic        w_tick;
    logic        w_expire;
    state_t      w_state_nxt;
    logic [15:0] w_count_nxt;
    logic [15:0] w_rd_val;

    // Unsigned offset compare also rejects addresses below BASE_ADDR (they wrap high).
    assign w_off = i_IO_addr - BASE_ADDR;
    assign w_hit = (w_off <= 8'd4);

    assign w_wr_ctrl     = i_IO_we && w_hit && (w_off[2:0] == OFF_CTRL);
    assign w_wr_reload   = i_IO_we && w_hit && (w_off[2:0] == OFF_RELOAD);
    assign w_wr_count    = i_IO_we && w_hit && (w_off[2:0] == OFF_COUNT);
    assign w_wr_status   = i_IO_we && w_hit && (w_off[2:0] == OFF_STATUS);
    assign w_wr_prescale = i_IO_we && w_hit && (w_off[2:0] == OFF_PRESCALE);

    timer_prescaler u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .en      (r_state == RUNNING),
        .clr     (w_wr_ctrl || w_wr_prescale),
        .divisor (r_prescale),
        .tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_expire    = 1'b0;
        case (r_state)
            STOPPED: ;
            RUNNING: begin
                // A COUNT write in the same cycle overrides the tick entirely.
                if (w_tick && !w_wr_count) begin
                    if (r_count > 16'd1) begin
                        w_count_nxt = r_count - 16'd1;
                    end else if (r_count == 16'd1) begin
                        w_expire = 1'b1;
                        if (r_auto) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = STOPPED;
                        end
                    end else begin
                        w_state_nxt = STOPPED;
                    end
                end
            end
            default: w_state_nxt = STOPPED;
        endcase
        if (w_wr_count) begin
            w_count_nxt = i_IO_data;
        end
        if (w_wr_ctrl) begin
            w_state_nxt = i_IO_data[CTRL_EN] ? RUNNING : STOPPED;
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (w_off[2:0])
            OFF_CTRL:     w_rd_val = {13'd0, r_ie, r_auto, r_state == RUNNING};
            OFF_RELOAD:   w_rd_val = r_reload;
            OFF_COUNT:    w_rd_val = r_count;
            OFF_STATUS:   w_rd_val = {15'd0, r_pend};
            OFF_PRESCALE: w_rd_val = r_prescale;
            default:      w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= STOPPED;
            r_auto     <= 1'b0;
            r_ie       <= 1'b0;
            r_pend     <= 1'b0;
            r_reload   <= '0;
            r_count    <= '0;
            r_prescale <= PRESCALE_RST;
            r_rdata    <= '0;
            r_intr     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_wr_ctrl) begin
                r_auto <= i_IO_data[CTRL_AUTO];
                r_ie   <= i_IO_data[CTRL_IE];
            end
            if (w_wr_reload) begin
                r_reload <= i_IO_data;
            end
            if (w_wr_prescale) begin
                r_prescale <= i_IO_data;
            end
            // Expiry beats a simultaneous clear.
            r_pend  <= w_expire || (r_pend && !(w_wr_status && i_IO_data[STATUS_PEND]));
            r_rdata <= (i_IO_re && w_hit) ? w_rd_val : 16'd0;
            r_intr  <= r_pend && r_ie;
        end
    end

    assign o_IO_data = r_rdata;
    assign o_intr    = r_intr;

endmodule

// File: doc/timer_io_wrap.md
Name: timer_io_wrap

Overview:
- Programmable interval timer peripheral on the 8-bit IO bus driven by mem_io, alongside uart_io_wrap and sd_io_wrap.
- Generates a periodic or one-shot interrupt for the cpu, providing a tick source for scheduling and timeouts.
- Reads are registered.
- Read data is zero when the block is not addressed, so it can be OR-combined onto the shared IO read bus.

Parameters:
- BASE_ADDR, 8'h20, IO address of register 0; the block decodes BASE_ADDR..BASE_ADDR+4.
- PRESCALE_RST, 16'd49, reset value of the prescaler divider (1 µs tick at 50 MHz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_IO_re  in  1  IO read strobe, one cycle.
- i_IO_we  in  1  IO write strobe, one cycle.
- i_IO_addr  in  8  IO register address.
- i_IO_data  in  16  IO write data.
- o_IO_data  out  16  IO read data, registered.
- o_intr  out  1  level interrupt to the cpu, registered.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous, active-high.
- Register map (offsets from BASE_ADDR):
  - 0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); bits 15:3 read as 0.
  - 1 RELOAD: 16-bit reload value.
  - 2 COUNT: read returns the live counter; write loads the counter.
  - 3 STATUS: bit0 PEND; writing 1 to bit0 clears PEND, writing 0 has no effect.
  - 4 PRESCALE: 16-bit divider; one tick every PRESCALE+1 clocks.
- Reset values:
  - CTRL=0, RELOAD=0, COUNT=0, PEND=0.
  - PRESCALE=PRESCALE_RST, prescaler counter=0.
  - o_IO_data=0, o_intr=0.
- Address decode: a strobe is honoured only when i_IO_addr is in BASE_ADDR..BASE_ADDR+4.
  - Reads of other addresses return 0.
  - Writes to other addresses are ignored.
- Read latency: o_IO_data holds the addressed register exactly 1 cycle after i_IO_re, and 0 on every other cycle.
- If i_IO_re and i_IO_we hit the same address in one cycle, the read returns the pre-write value.
- Prescaler:
  - pcnt increments each clock while EN=1.
  - When pcnt==PRESCALE, a tick pulse is asserted for 1 cycle and pcnt wraps to 0.
  - pcnt is held at 0 while EN=0.
  - Any write to PRESCALE or CTRL also clears pcnt.
- State machine, two states:
  - STOPPED (EN=0): COUNT is frozen.
  - RUNNING (EN=1): on each tick:
    - COUNT>1: COUNT-=1.
    - COUNT==1: expiry. PEND<=1, and:
      - AUTO=1: COUNT<=RELOAD.
      - AUTO=0: COUNT<=0 and EN<=0, transitioning to STOPPED.
    - COUNT==0: no decrement and no expiry; EN<=0, transitioning to STOPPED.
  - Transition STOPPED->RUNNING only via a CTRL write with EN=1.
- Expiry timing: first expiry occurs (COUNT_initial)*(PRESCALE+1) clocks after EN is written, ±0 cycles.
- AUTO with RELOAD=0: the first expiry loads 0, and the next tick stops the timer.
- Interrupt: o_intr <= PEND & IE, registered, so it appears 1 cycle after PEND sets or IE is written.
- Simultaneous events:
  - Expiry and a STATUS clear in the same cycle: expiry wins, PEND stays 1.
  - COUNT write and a tick in the same cycle: the write wins, with no decrement that cycle.
  - CTRL write with EN=0 and an expiry in the same cycle: PEND still sets, EN ends at 0.
- Reset mid-count: all state returns to reset values on the next edge; any pending interrupt drops 1 cycle later, with o_intr=0 after the reset edge.
- Arithmetic: all counters are 16-bit unsigned; no wrap below 0 ever occurs.

Decomposition:
- Package timer_pkg:
  - Register offset constants: OFF_CTRL=0, OFF_RELOAD=1, OFF_COUNT=2, OFF_STATUS=3, OFF_PRESCALE=4.
  - CTRL bit indices: EN=0, AUTO=1, IE=2.
  - STATUS_PEND=0.
  - State enum {STOPPED, RUNNING}.
- Sub-module timer_prescaler (inputs: clk, reset, en, clr, divisor[15:0]; output: tick) holds pcnt and the tick compare.
- The register file, down-counter, FSM and read mux live in timer_io_wrap.

Test Plan:
- Reset, then read all 5 offsets -> CTRL=0, RELOAD=0, COUNT=0, STATUS=0, PRESCALE=49; o_IO_data=0 on non-read cycles; read of BASE+5 returns 0.
- One-shot: PRESCALE=0, COUNT=3, CTRL=0b101 -> PEND sets exactly 3 clocks after the CTRL write; o_intr high 1 cycle later; CTRL reads EN=0; COUNT=0.
- Auto-reload: PRESCALE=4, RELOAD=10, COUNT=10, CTRL=0b111 -> PEND sets every 50 clocks; write 1 to STATUS clears PEND and o_intr drops next cycle; timer keeps running.
- Collision: align a STATUS clear write with an expiry cycle -> PEND remains 1; align a COUNT=7 write with a tick -> COUNT reads 7.
- IE gating: IE=0 and expiry -> PEND=1, o_intr=0; then write CTRL IE=1 -> o_intr=1 one cycle later.
- Mid-run reset: assert reset during COUNT=500 with AUTO -> next cycle all registers at reset values, o_intr=0, no further expiry.
